// File: rtl/nrzi_pkg.sv
// Shared types and helpers for the NRZI bit-stuffing transmitter and its line encoder.
package nrzi_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_STUFF
    } e_tx_state;

    typedef enum logic [1:0] {
        LINE_HOLD,
        LINE_EMIT,
        LINE_IDLE
    } e_line_cmd;

    // True when this raw bit must flip the line level.
    function automatic logic nrzi_toggle(input logic raw, input logic toggle_on_zero);
        return raw ^ toggle_on_zero;
    endfunction

endpackage

// File: rtl/nrzi_line_enc.sv
// NRZI line register pair: level y and driver enable oe, updated by a one-of-three command.
module nrzi_line_enc
    import nrzi_pkg::*;
#(
    parameter int IDLE_LEVEL     = 1,
    parameter int TOGGLE_ON_ZERO = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    input  e_line_cmd cmd,
    input  logic      raw,
    output logic      y,
    output logic      oe
);

    localparam logic IDLE_BIT = (IDLE_LEVEL != 0);
    localparam logic TOG_ZERO = (TOGGLE_ON_ZERO != 0);

    // NOTE: sequential state is written only with non-blocking assignments so every
    // register samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y  <= IDLE_BIT;
            oe <= 1'b0;
        end else begin
            case (cmd)
                LINE_EMIT: begin
                    if (nrzi_toggle(raw, TOG_ZERO)) y <= ~y;
                    oe <= 1'b1;
                end
                LINE_IDLE: begin
                    y  <= IDLE_BIT;
                    oe <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/nrzi_stuff_tx.sv
// Parallel-in NRZI line transmitter with bit stuffing: holding register, LSB-first shifter,
// ones counter and a three-state sequencer driving the shared line encoder.
module nrzi_stuff_tx
    import nrzi_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int STUFF_LEN      = 6,
    parameter int IDLE_LEVEL     = 1,
    parameter int TOGGLE_ON_ZERO = 1
) (
    input  logic              clk_i,
    input  logic              resetn_i,
    input  logic              bit_en_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              last_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              y_o,
    output logic              oe_o,
    output logic              stuff_o,
    output logic              underrun_o,
    output logic              busy_o
);

    localparam int                CNT_W    = $clog2(STUFF_LEN + 1);
    localparam int                IDX_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STUFF_LEN);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DATA_W - 1);

    logic [DATA_W-1:0] hold_data;
    logic              hold_last;
    logic              hold_full;

    logic [DATA_W-1:0] sh_data;
    logic [IDX_W-1:0]  sh_idx;
    logic              sh_last;
    logic              sh_full;

    logic [CNT_W-1:0]  ones_cnt;
    e_tx_state         state;
    logic              final_sent;
    logic              stuff_q;
    logic              underrun_q;

    logic              accept;
    logic              shift_bit;
    logic              stuff_bit;
    logic              underrun;
    logic              raw_bit;
    logic              word_done;
    logic              load;
    logic              stuff_due;
    logic [CNT_W-1:0]  cnt_next;
    e_line_cmd         line_cmd;
    logic              line_raw;

    // NOTE: every signal driven here gets a default before any condition, so no
    // path through the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        accept    = valid_i & ~hold_full;
        shift_bit = (state == S_SHIFT) & bit_en_i & sh_full;
        stuff_bit = (state == S_STUFF) & bit_en_i;
        underrun  = (state == S_SHIFT) & bit_en_i & ~sh_full & ~hold_full;
        raw_bit   = sh_data[sh_idx];
        word_done = shift_bit & (sh_idx == IDX_LAST);
        // Reloading on the edge that shifts out the last bit keeps words gap-free.
        load      = hold_full & (~sh_full | word_done);

        if (!raw_bit)                cnt_next = '0;
        else if (ones_cnt == CNT_MAX) cnt_next = ones_cnt;
        else                         cnt_next = ones_cnt + CNT_W'(1);
        stuff_due = shift_bit & (cnt_next == CNT_MAX);

        line_cmd = LINE_HOLD;
        line_raw = raw_bit;
        if (shift_bit) begin
            line_cmd = LINE_EMIT;
        end else if (stuff_bit) begin
            line_cmd = LINE_EMIT;
            line_raw = 1'b0;
        end else if (underrun || ((state == S_IDLE) && bit_en_i)) begin
            line_cmd = LINE_IDLE;
        end
    end

    // NOTE: the word storage is reset along with the control flags; the buffers are
    // only two words deep, and a cleared datapath makes post-reset state deterministic.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            hold_data <= '0;
            hold_last <= 1'b0;
            hold_full <= 1'b0;
            sh_data   <= '0;
            sh_idx    <= '0;
            sh_last   <= 1'b0;
            sh_full   <= 1'b0;
        end else begin
            if (accept) begin
                hold_data <= data_i;
                hold_last <= last_i;
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end

            if (load) begin
                sh_data <= hold_data;
                sh_last <= hold_last;
                sh_idx  <= '0;
                sh_full <= 1'b1;
            end else if (shift_bit) begin
                sh_idx <= sh_idx + IDX_W'(1);
                if (word_done) sh_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state      <= S_IDLE;
            ones_cnt   <= '0;
            final_sent <= 1'b0;
            stuff_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            stuff_q    <= stuff_bit;
            underrun_q <= underrun;
            unique case (state)
                S_IDLE: begin
                    ones_cnt   <= '0;
                    final_sent <= 1'b0;
                    // A still-driven line must first return to idle on a strobe.
                    if ((sh_full || load) && (!oe_o || bit_en_i)) state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (underrun) begin
                        state    <= S_IDLE;
                        ones_cnt <= '0;
                    end else if (shift_bit) begin
                        ones_cnt <= cnt_next;
                        if (stuff_due) begin
                            state      <= S_STUFF;
                            final_sent <= word_done & sh_last;
                        end else if (word_done && sh_last) begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_STUFF: begin
                    if (bit_en_i) begin
                        ones_cnt <= '0;
                        state    <= final_sent ? S_IDLE : S_SHIFT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    nrzi_line_enc #(
        .IDLE_LEVEL     (IDLE_LEVEL),
        .TOGGLE_ON_ZERO (TOGGLE_ON_ZERO)
    ) u_line (
        .clk   (clk_i),
        .rst_n (resetn_i),
        .cmd   (line_cmd),
        .raw   (line_raw),
        .y     (y_o),
        .oe    (oe_o)
    );

    assign ready_o    = ~hold_full;
    assign busy_o     = (state != S_IDLE);
    assign stuff_o    = stuff_q;
    assign underrun_o = underrun_q;

endmodule
